// File: rtl/counter_arbiter_pkg.sv
// Shared types and helpers for the counter_arbiter block.
package counter_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NREQ_DEF  = 2;
    localparam int unsigned WIDTH_DEF = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick
    import counter_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] sel,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // Two passes: indices at/after ptr first, then the wrapped lower indices.
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (IDXW'(j) >= ptr)) begin
                any    = 1'b1;
                sel[j] = 1'b1;
                idx    = IDXW'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any && req[j]) begin
                any    = 1'b1;
                sel[j] = 1'b1;
                idx    = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin sharing of one up-counter between NREQ requesters. Each grant
// runs the counter 0..len-1, pulses done, then releases.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NREQ  = NREQ_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic                  abort,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    localparam int unsigned IDXW = idx_width(NREQ);

    state_t           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [NREQ-1:0]  gnt_d, done_d;
    logic             cnt_clr, cnt_en;

    logic [NREQ-1:0]  pick_sel;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] len_sel;
    logic [IDXW-1:0]  ptr_after;
    logic             held;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Length slice of the requester being picked this cycle.
    always_comb begin
        len_sel = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (pick_sel[j]) len_sel = len[j*WIDTH +: WIDTH];
        end
    end

    assign ptr_after = (idx_q == IDXW'(NREQ-1)) ? '0 : idx_q + IDXW'(1);
    assign held      = |(req & gnt);

    // Next-state, grant, done and counter-control decisions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        gnt_d   = gnt;
        done_d  = '0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!abort && pick_any) begin
                    gnt_d = pick_sel;
                    idx_d = pick_idx;
                    len_d = len_sel;
                    if (len_sel == '0) begin
                        state_d = DONE;
                        done_d  = pick_sel;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // abort outranks both early release and normal completion
                if (abort || !held) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_after;
                    cnt_clr = 1'b1;
                end else if (count == len_q - WIDTH'(1)) begin
                    state_d = DONE;
                    done_d  = gnt;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_after;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            gnt     <= gnt_d;
            busy    <= |gnt_d;
            done    <= done_d;
        end
    end

    // Shared counter datapath with clear and enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (cnt_en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter (WIDTH=8, NREQ=2).
module tb_counter_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] len = '0;
    logic        abort = 1'b0;
    logic [1:0]  gnt;
    logic        busy;
    logic [7:0]  count;
    logic [1:0]  done;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    counter_arbiter #(
        .WIDTH (8),
        .NREQ  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .abort (abort),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        req   = '0;
        abort = 1'b0;
        reset = 1'b0;
        #1;
        check({tag, "_rst_gnt"},   32'(gnt),   32'h0);
        check({tag, "_rst_busy"},  32'(busy),  32'h0);
        check({tag, "_rst_count"}, 32'(count), 32'h0);
        check({tag, "_rst_done"},  32'(done),  32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // single request, len=5; len change mid-run must be ignored
        do_reset("init");
        req = 2'b01;
        len = {8'd0, 8'd5};
        step();
        check("single_gnt",  32'(gnt),   32'h1);
        check("single_busy", 32'(busy),  32'h1);
        check("single_c0",   32'(count), 32'h0);
        len = {8'd0, 8'd2};
        for (int k = 1; k <= 4; k++) begin
            step();
            check("single_cnt", 32'(count), 32'(k));
            check("single_nodone", 32'(done), 32'h0);
        end
        step();
        check("single_done",  32'(done),  32'h1);
        check("single_hold",  32'(count), 32'h4);
        check("single_dgnt",  32'(gnt),   32'h1);
        req = 2'b00;
        step();
        check("single_rel_gnt",  32'(gnt),   32'h0);
        check("single_rel_busy", 32'(busy),  32'h0);
        check("single_rel_cnt",  32'(count), 32'h0);
        check("single_rel_done", 32'(done),  32'h0);

        // contention: both requesting from reset, len[1]=3, len[0]=4
        do_reset("cont");
        req = 2'b11;
        len = {8'd3, 8'd4};
        step();
        check("cont_g0", 32'(gnt), 32'h1);
        repeat (3) step();
        check("cont_c3", 32'(count), 32'h3);
        step();
        check("cont_done0", 32'(done), 32'h1);
        check("cont_hold0", 32'(count), 32'h3);
        step();
        check("cont_idle", 32'(gnt), 32'h0);
        check("cont_idle_busy", 32'(busy), 32'h0);
        step();
        check("cont_g1", 32'(gnt), 32'h2);
        check("cont_g1_c0", 32'(count), 32'h0);
        repeat (2) step();
        check("cont_c2", 32'(count), 32'h2);
        step();
        check("cont_done1", 32'(done), 32'h2);
        step();
        check("cont_idle2", 32'(gnt), 32'h0);
        step();
        check("cont_g0_again", 32'(gnt), 32'h1);
        repeat (6) step();
        check("cont_g1_again", 32'(gnt), 32'h2);

        // zero-length window on requester 1
        do_reset("zero");
        req = 2'b10;
        len = {8'd0, 8'd7};
        step();
        check("zero_gnt",  32'(gnt),   32'h2);
        check("zero_done", 32'(done),  32'h2);
        check("zero_cnt",  32'(count), 32'h0);
        req = 2'b00;
        step();
        check("zero_idle_gnt",  32'(gnt),  32'h0);
        check("zero_idle_done", 32'(done), 32'h0);

        // early release at count=3, then pointer must favour requester 1
        do_reset("early");
        req = 2'b01;
        len = {8'd4, 8'd10};
        step();
        repeat (3) step();
        check("early_c3", 32'(count), 32'h3);
        req = 2'b00;
        step();
        check("early_gnt",  32'(gnt),   32'h0);
        check("early_cnt",  32'(count), 32'h0);
        check("early_done", 32'(done),  32'h0);
        req = 2'b11;
        step();
        check("early_ptr", 32'(gnt), 32'h2);

        // abort in RUN at count=2, pending 11 goes to requester 1
        do_reset("abort");
        req = 2'b01;
        len = {8'd2, 8'd6};
        step();
        repeat (2) step();
        check("abort_c2", 32'(count), 32'h2);
        abort = 1'b1;
        req   = 2'b11;
        step();
        check("abort_gnt",  32'(gnt),  32'h0);
        check("abort_done", 32'(done), 32'h0);
        abort = 1'b0;
        step();
        check("abort_next", 32'(gnt), 32'h2);

        // abort while idle blocks the grant for that cycle
        do_reset("abidle");
        req   = 2'b01;
        abort = 1'b1;
        step();
        check("abidle_nogrant", 32'(gnt), 32'h0);
        abort = 1'b0;
        step();
        check("abidle_grant", 32'(gnt), 32'h1);

        // async reset mid-RUN with pointer at 1; after release pointer is 0
        do_reset("async");
        req = 2'b01;
        len = {8'd5, 8'd0};
        step();
        check("async_z_done", 32'(done), 32'h1);
        req = 2'b10;
        step();
        step();
        check("async_g1", 32'(gnt), 32'h2);
        step();
        check("async_c1", 32'(count), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_gnt",   32'(gnt),   32'h0);
        check("async_busy",  32'(busy),  32'h0);
        check("async_count", 32'(count), 32'h0);
        check("async_done",  32'(done),  32'h0);
        reset = 1'b1;
        req   = 2'b11;
        step();
        check("async_ptr0", 32'(gnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
